i2c_target: RTL and testbench

- I2C responder for the far end of the bus driven by our I2C controller.
- Oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit own address, then receives bytes (controller write) or transmits bytes (controller read).
- ACKs and data bits are driven open-drain on SDA.
- Sits behind an I/O pad on the peripheral side of the design, or in the bench as the controller's bus model.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_bus_monitor.sv | 45 ++++
 rtl/i2c_target.sv | 153 +++++++++++++++
 tb/tb_i2c_target.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, R/W bit values and the general-call address.
package i2c_pkg;
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_ADDR      = 4'd1;
  localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
  localparam logic [3:0] ST_RX_BYTE   = 4'd3;
  localparam logic [3:0] ST_RX_ACK    = 4'd4;
  localparam logic [3:0] ST_TX_BYTE   = 4'd5;
  localparam logic [3:0] ST_TX_ACK    = 4'd6;
  localparam logic [3:0] ST_WAIT_STOP = 4'd7;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam logic [6:0] GEN_CALL_ADDR = 7'h00;
  localparam logic [3:0] BYTE_BITS     = 4'd8;
endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Everything resets to the idle-bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl & r_scl_prev;
  assign o_start    = w_scl & r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & ~r_sda_prev & w_sda;
endmodule

// File: rtl/i2c_target.sv
// I2C target: address match, byte receive/transmit, open-drain SDA.
// Optional general-call ACK enabled by defining I2C_TARGET_GENERAL_CALL_EN.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] OWN_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] tx_byte,
  output logic       tx_req,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       gen_call,
  output logic [3:0] state
);
  logic       w_sda, w_rise, w_fall, w_start, w_stop;
  logic [3:0] r_state, w_next_state;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_rx_byte;
  logic       r_rx_valid, r_tx_req, r_busy;
  logic       w_sda_oe, w_addr_match, w_byte_done, w_rw;
  logic [6:0] w_addr;

  i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
    .clk        (clk),
    .reset      (reset),
    .i_scl      (scl),
    .i_sda      (sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_addr      = r_shift[7:1];
  assign w_rw        = r_shift[0];
  assign w_byte_done = w_fall && (r_cnt == BYTE_BITS);

`ifdef I2C_TARGET_GENERAL_CALL_EN
  logic r_gen_call;
  assign w_addr_match = (w_addr == GEN_CALL_ADDR) ? (w_rw == RW_WRITE) : (w_addr == OWN_ADDR);
  always_ff @(posedge clk) begin
    if (reset || w_start || w_stop) r_gen_call <= 1'b0;
    else if (r_state == ST_ADDR && w_byte_done && w_addr_match && w_addr == GEN_CALL_ADDR)
      r_gen_call <= 1'b1;
  end
  assign gen_call = r_gen_call;
`else
  assign w_addr_match = (w_addr == OWN_ADDR);
  assign gen_call     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // START/STOP override any SCL edge seen in the same cycle.
  always_comb begin
    w_next_state = r_state;
    if (w_start)     w_next_state = ST_ADDR;
    else if (w_stop) w_next_state = ST_IDLE;
    else begin
      case (r_state)
        ST_ADDR:     if (w_byte_done) w_next_state = w_addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK: if (w_fall) w_next_state = (w_rw == RW_READ) ? ST_TX_BYTE : ST_RX_BYTE;
        ST_RX_BYTE:  if (w_byte_done) w_next_state = ST_RX_ACK;
        ST_RX_ACK:   if (w_fall) w_next_state = ST_RX_BYTE;
        ST_TX_BYTE:  if (w_byte_done) w_next_state = ST_TX_ACK;
        ST_TX_ACK: begin
          if (w_rise && w_sda) w_next_state = ST_WAIT_STOP;
          else if (w_fall)     w_next_state = ST_TX_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rx_byte  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_start) r_cnt <= '0;
      else if (w_stop) r_busy <= 1'b0;
      else begin
        if (w_rise && r_cnt != BYTE_BITS &&
            (r_state == ST_ADDR || r_state == ST_RX_BYTE || r_state == ST_TX_BYTE))
          r_cnt <= r_cnt + 4'd1;
        if (w_fall) begin
          case (r_state)
            ST_ADDR:     if (w_byte_done) r_busy <= w_addr_match;
            ST_ADDR_ACK: begin
              r_cnt    <= '0;
              r_tx_req <= (w_rw == RW_READ);
            end
            ST_RX_BYTE: if (w_byte_done) begin
              r_rx_byte  <= r_shift;
              r_rx_valid <= 1'b1;
            end
            ST_RX_ACK: r_cnt <= '0;
            ST_TX_ACK: begin
              r_cnt    <= '0;
              r_tx_req <= 1'b1;
            end
            default: ;
          endcase
        end
        if (r_state == ST_TX_ACK && w_rise && w_sda) r_busy <= 1'b0;
      end
    end
  end

  // The shifter carries the address/receive byte in, or the transmit byte out MSB first.
  always_ff @(posedge clk) begin
    if (!w_start && !w_stop) begin
      if (w_rise && (r_state == ST_ADDR || r_state == ST_RX_BYTE))
        r_shift <= {r_shift[6:0], w_sda};
      else if (w_fall && ((r_state == ST_ADDR_ACK && w_rw == RW_READ) || r_state == ST_TX_ACK))
        r_shift <= tx_byte;
      else if (w_fall && r_state == ST_TX_BYTE)
        r_shift <= {r_shift[6:0], 1'b0};
    end
  end

  always_comb begin
    w_sda_oe = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_RX_ACK: w_sda_oe = 1'b1;
      ST_TX_BYTE:             w_sda_oe = ~r_shift[7];
      default: ;
    endcase
  end

  assign sda      = w_sda_oe ? 1'b0 : 1'bz;
  assign state    = r_state;
  assign busy     = r_busy;
  assign rx_byte  = r_rx_byte;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus controller plus a transaction-level expectation model.
// Expectations for general call follow I2C_TARGET_GENERAL_CALL_EN when defined.
module tb_i2c_target;
  localparam logic [6:0] OWN = 7'h50;
`ifdef I2C_TARGET_GENERAL_CALL_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  wire        sda;
  logic       tx_req, rx_valid, busy, gen_call;
  logic [7:0] rx_byte;
  logic [3:0] state;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_target #(.OWN_ADDR(OWN), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .tx_byte(tx_byte),
    .tx_req(tx_req), .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .gen_call(gen_call), .state(state)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_rx_q[$];
  int         exp_txreq = 0;
  int         rxv_seen = 0;
  int         txr_seen = 0;
  logic       m_busy = 1'b0;
  logic       m_gc = 1'b0;
  logic       win = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of pulses and status against the model.
  always @(posedge clk) begin
    #2;
    if (rx_valid === 1'b1) begin
      rxv_seen++;
      if (exp_rx_q.size() == 0) check("rx_valid_unexpected", 32'd1, 32'd0);
      else check("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx_q.pop_front()});
    end
    if (tx_req === 1'b1) begin
      txr_seen++;
      check("tx_req_expected", {31'd0, exp_txreq > 0}, 32'd1);
      if (exp_txreq > 0) exp_txreq--;
    end
    if (win) begin
      check("busy", {31'd0, busy}, {31'd0, m_busy});
      check("gen_call", {31'd0, gen_call}, {31'd0, m_gc});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic val, output logic seen);
    wait_clk(4); m_low = ~val;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); seen = sda; win = 1'b1;
    wait_clk(4); win = 1'b0; scl = 1'b0;
  endtask

  task automatic do_start();
    if (scl == 1'b0) begin
      wait_clk(4); m_low = 1'b0;
      wait_clk(4); scl = 1'b1;
    end
    wait_clk(8); m_low = 1'b1; m_gc = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic do_stop();
    wait_clk(4); m_low = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); m_low = 1'b0; m_busy = 1'b0; m_gc = 1'b0;
    wait_clk(8);
  endtask

  function automatic logic model_ack(input logic [6:0] a, input logic rw);
    return (a == OWN) || (GC_EN && a == 7'h00 && rw == 1'b0);
  endfunction

  task automatic send_addr(input logic [6:0] a, input logic rw, input logic [7:0] first_tx,
                           output logic acked);
    logic       seen, exp_sda;
    logic [7:0] b;
    b = {a, rw};
    acked = model_ack(a, rw);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], seen);
    m_busy = acked;
    m_gc   = acked && (a == 7'h00);
    if (acked && rw) begin
      tx_byte = first_tx;
      exp_txreq++;
    end
    clock_bit(1'b1, seen);
    exp_sda = ~acked;
    check("addr_ack", {31'd0, seen}, {31'd0, exp_sda});
  endtask

  task automatic send_data(input logic [7:0] b);
    logic seen;
    exp_rx_q.push_back(b);
    for (int i = 7; i >= 0; i--) clock_bit(b[i], seen);
    clock_bit(1'b1, seen);
    check("data_ack", {31'd0, seen}, 32'd0);
  endtask

  task automatic recv_byte(input logic [7:0] exp_b, input logic ack, input logic [7:0] next_tx,
                           input string nm);
    logic       seen;
    logic [7:0] got;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, seen);
      got[i] = seen;
    end
    check(nm, {24'd0, got}, {24'd0, exp_b});
    if (ack) begin
      tx_byte = next_tx;
      exp_txreq++;
    end else m_busy = 1'b0;
    clock_bit(~ack, seen);
  endtask

  task automatic write_txn(input logic [6:0] a, input int n);
    logic ok;
    do_start();
    send_addr(a, 1'b0, 8'h00, ok);
    if (ok) for (int i = 0; i < n; i++) send_data(8'($urandom));
    else check("wr_nack_state", {28'd0, state}, 32'd7);
    do_stop();
    check("wr_end_state", {28'd0, state}, 32'd0);
    check("wr_end_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_txn(input logic [6:0] a, input int n);
    logic       ok;
    logic [7:0] cur, nxt;
    cur = 8'($urandom);
    do_start();
    send_addr(a, 1'b1, cur, ok);
    if (ok) for (int i = 0; i < n; i++) begin
      nxt = 8'($urandom);
      recv_byte(cur, i < n - 1, nxt, "rd_data");
      cur = nxt;
    end
    check("rd_end_wait_stop", {28'd0, state}, 32'd7);
    do_stop();
    check("rd_end_state", {28'd0, state}, 32'd0);
  endtask

  initial begin
    logic       ok, seen;
    logic [6:0] a;
    int         rx0, tx0;
    logic [7:0] part;

    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_sda", {31'd0, sda}, 32'd1);
    check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rst_flags", {28'd0, rx_valid, tx_req, busy, gen_call}, 32'd0);

    // Write 0xA5, 0x3C to own address.
    rx0 = rxv_seen;
    do_start();
    send_addr(OWN, 1'b0, 8'h00, ok);
    send_data(8'hA5);
    send_data(8'h3C);
    check("wr_busy_before_stop", {31'd0, busy}, 32'd1);
    do_stop();
    check("wr_rx_byte_last", {24'd0, rx_byte}, 32'h3C);
    check("wr_rxv_count", rxv_seen - rx0, 32'd2);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read 0x96 then 0x0F; ACK first, NACK second.
    tx0 = txr_seen;
    do_start();
    send_addr(OWN, 1'b1, 8'h96, ok);
    recv_byte(8'h96, 1'b1, 8'h0F, "rd_lit0");
    recv_byte(8'h0F, 1'b0, 8'h00, "rd_lit1");
    check("rd_txreq_count", txr_seen - tx0, 32'd2);
    check("rd_nack_state", {28'd0, state}, 32'd7);
    do_stop();
    check("rd_idle", {28'd0, state}, 32'd0);

    // Non-matching address.
    rx0 = rxv_seen;
    do_start();
    send_addr(7'h51, 1'b0, 8'h00, ok);
    check("miss_state", {28'd0, state}, 32'd7);
    do_stop();
    check("miss_rxv", rxv_seen - rx0, 32'd0);
    check("miss_idle", {28'd0, state}, 32'd0);

    // Repeated START after 4 data bits, then a read.
    rx0 = rxv_seen;
    part = 8'hB7;
    do_start();
    send_addr(OWN, 1'b0, 8'h00, ok);
    for (int i = 7; i >= 4; i--) clock_bit(part[i], seen);
    do_start();
    check("rs_state_addr", {28'd0, state}, 32'd1);
    send_addr(OWN, 1'b1, 8'h5A, ok);
    recv_byte(8'h5A, 1'b0, 8'h00, "rs_data");
    do_stop();
    check("rs_no_rxv", rxv_seen - rx0, 32'd0);

    // Reset while the target holds the data ACK low.
    do_start();
    send_addr(OWN, 1'b0, 8'h00, ok);
    part = 8'hC3;
    exp_rx_q.push_back(part);
    for (int i = 7; i >= 0; i--) clock_bit(part[i], seen);
    wait_clk(4); m_low = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(4);
    check("rstmid_ack_low", {31'd0, sda}, 32'd0);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    m_busy = 1'b0;
    m_gc = 1'b0;
    check("rstmid_state", {28'd0, state}, 32'd0);
    check("rstmid_sda", {31'd0, sda}, 32'd1);
    check("rstmid_rx_byte", {24'd0, rx_byte}, 32'd0);
    check("rstmid_flags", {28'd0, rx_valid, tx_req, busy, gen_call}, 32'd0);
    wait_clk(4); scl = 1'b0;
    do_stop();

    // General call write of 0x06.
    do_start();
    send_addr(7'h00, 1'b0, 8'h00, ok);
    check("gc_flag", {31'd0, gen_call}, {31'd0, GC_EN});
    if (ok) begin
      send_data(8'h06);
      check("gc_rx_byte", {24'd0, rx_byte}, 32'h06);
    end else check("gc_nack_state", {28'd0, state}, 32'd7);
    do_stop();
    check("gc_cleared", {31'd0, gen_call}, 32'd0);

    // Randomised transactions.
    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = OWN;
        2:       a = 7'h00;
        default: a = 7'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) write_txn(a, int'($urandom_range(1, 3)));
      else                           read_txn(a, int'($urandom_range(1, 3)));
    end

    wait_clk(4);
    check("rx_queue_drained", exp_rx_q.size(), 32'd0);
    check("tx_req_all_seen", exp_txreq, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
